// File: rtl/acl_frame_gate.sv
// rtl/acl_frame_gate.sv - store-and-forward frame gate releasing or discarding each frame on the parser verdict
// One frame in flight: buffer it, wait for allow/deny (or time out), then forward or flush it.
module acl_frame_gate #(
    parameter int C_s_axis_rxd_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH               = 512,
    parameter int VERDICT_TIMEOUT          = 64,
    parameter int CNT_WIDTH                = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [C_s_axis_rxd_TDATA_WIDTH-1:0] i_rxd_tdata,
    input  logic                                i_rxd_tvalid,
    input  logic                                i_rxd_tlast,
    output logic                                o_rxd_tready,
    input  logic                                i_verdict_valid,
    input  logic                                i_deny_data,
    output logic [C_s_axis_rxd_TDATA_WIDTH-1:0] o_txd_tdata,
    output logic                                o_txd_tvalid,
    output logic                                o_txd_tlast,
    input  logic                                i_txd_tready,
    output logic [CNT_WIDTH-1:0]                o_frames_passed,
    output logic [CNT_WIDTH-1:0]                o_frames_dropped,
    output logic [CNT_WIDTH-1:0]                o_verdict_timeouts,
    output logic                                o_oversize
);
    localparam int DW = C_s_axis_rxd_TDATA_WIDTH;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(VERDICT_TIMEOUT + 1);
    localparam logic [PW-1:0]        LP_DEPTH   = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0]        LP_PONE    = PW'(1);
    localparam logic [TW-1:0]        LP_TIMEOUT = TW'(VERDICT_TIMEOUT);
    localparam logic [TW-1:0]        LP_TONE    = TW'(1);
    localparam logic [CNT_WIDTH-1:0] LP_CONE    = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WAIT,
        S_FORWARD,
        S_FLUSH
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [DW-1:0]        r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [TW-1:0]        r_timer;
    logic                 r_verdict_seen;
    logic                 r_verdict_deny;
    logic                 r_oversize_frame;
    logic                 r_oversize;
    logic                 r_rxd_tready;
    logic [CNT_WIDTH-1:0] r_passed;
    logic [CNT_WIDTH-1:0] r_dropped;
    logic [CNT_WIDTH-1:0] r_timeouts;

    logic          w_rx_fire;
    logic          w_tx_fire;
    logic          w_store;
    logic          w_last_word;
    logic          w_verdict_have;
    logic          w_deny;
    logic          w_decide;
    logic          w_pass;
    logic          w_timeout_drop;
    logic [TW-1:0] w_timer_next;

    // r_wr_ptr saturates at FIFO_DEPTH, so it doubles as the stored word count
    assign w_rx_fire      = i_rxd_tvalid && r_rxd_tready;
    assign w_store        = w_rx_fire && (r_wr_ptr < LP_DEPTH);
    assign w_last_word    = (r_rd_ptr == (r_wr_ptr - LP_PONE));
    assign w_tx_fire      = (r_state == S_FORWARD) && i_txd_tready;
    assign w_verdict_have = r_verdict_seen || i_verdict_valid;
    assign w_deny         = r_verdict_seen ? r_verdict_deny : i_deny_data;
    assign w_timer_next   = r_timer + LP_TONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_decide       = 1'b0;
        w_pass         = 1'b0;
        w_timeout_drop = 1'b0;
        o_txd_tvalid   = 1'b0;
        o_txd_tlast    = 1'b0;
        o_txd_tdata    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_rx_fire) begin
                    w_state_next = i_rxd_tlast ? S_WAIT : S_RECV;
                end
            end
            S_RECV: begin
                if (w_rx_fire && i_rxd_tlast) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_verdict_have) begin
                    w_decide = 1'b1;
                    w_pass   = !w_deny && !r_oversize_frame;
                end else if (w_timer_next == LP_TIMEOUT) begin
                    w_decide       = 1'b1;
                    w_timeout_drop = 1'b1;
                end
                if (w_decide) begin
                    w_state_next = w_pass ? S_FORWARD : S_FLUSH;
                end
            end
            S_FORWARD: begin
                o_txd_tvalid = 1'b1;
                o_txd_tdata  = r_mem[r_rd_ptr[AW-1:0]];
                o_txd_tlast  = w_last_word;
                if (i_txd_tready && w_last_word) begin
                    w_state_next = S_IDLE;
                end
            end
            S_FLUSH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Buffer is never written outside IDLE/RECV, which keeps egress data stable
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_rxd_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_timer          <= '0;
            r_verdict_seen   <= 1'b0;
            r_verdict_deny   <= 1'b0;
            r_oversize_frame <= 1'b0;
            r_oversize       <= 1'b0;
            r_rxd_tready     <= 1'b0;
            r_passed         <= '0;
            r_dropped        <= '0;
            r_timeouts       <= '0;
        end else begin
            r_rxd_tready <= (w_state_next == S_IDLE) || (w_state_next == S_RECV);

            if (w_rx_fire) begin
                if (r_wr_ptr < LP_DEPTH) begin
                    r_wr_ptr <= r_wr_ptr + LP_PONE;
                end else begin
                    r_oversize_frame <= 1'b1;
                    r_oversize       <= 1'b1;
                end
            end

            if (w_decide) begin
                r_verdict_seen <= 1'b0;
                r_verdict_deny <= 1'b0;
            end else if (i_verdict_valid && !r_verdict_seen &&
                         ((r_state == S_IDLE && w_rx_fire) || r_state == S_RECV || r_state == S_WAIT)) begin
                r_verdict_seen <= 1'b1;
                r_verdict_deny <= i_deny_data;
            end

            if (r_state == S_WAIT && !w_decide) begin
                r_timer <= w_timer_next;
            end else begin
                r_timer <= '0;
            end

            if (w_timeout_drop && r_timeouts != '1) begin
                r_timeouts <= r_timeouts + LP_CONE;
            end

            if (w_tx_fire) begin
                if (w_last_word) begin
                    r_rd_ptr         <= '0;
                    r_wr_ptr         <= '0;
                    r_oversize_frame <= 1'b0;
                    if (r_passed != '1) begin
                        r_passed <= r_passed + LP_CONE;
                    end
                end else begin
                    r_rd_ptr <= r_rd_ptr + LP_PONE;
                end
            end

            if (r_state == S_FLUSH) begin
                r_rd_ptr         <= '0;
                r_wr_ptr         <= '0;
                r_oversize_frame <= 1'b0;
                if (r_dropped != '1) begin
                    r_dropped <= r_dropped + LP_CONE;
                end
            end
        end
    end

    assign o_rxd_tready       = r_rxd_tready;
    assign o_frames_passed    = r_passed;
    assign o_frames_dropped   = r_dropped;
    assign o_verdict_timeouts = r_timeouts;
    assign o_oversize         = r_oversize;

endmodule

// File: tb/tb_acl_frame_gate.sv
// tb/tb_acl_frame_gate.sv - scoreboard bench for acl_frame_gate with directed and randomized frames
module tb_acl_frame_gate;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int TMO   = 64;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] i_rxd_tdata = '0;
    logic          i_rxd_tvalid = 1'b0;
    logic          i_rxd_tlast = 1'b0;
    logic          o_rxd_tready;
    logic          i_verdict_valid = 1'b0;
    logic          i_deny_data = 1'b0;
    logic [DW-1:0] o_txd_tdata;
    logic          o_txd_tvalid;
    logic          o_txd_tlast;
    logic          i_txd_tready;
    logic [CW-1:0] o_frames_passed;
    logic [CW-1:0] o_frames_dropped;
    logic [CW-1:0] o_verdict_timeouts;
    logic          o_oversize;

    always #5 clk = ~clk;

    acl_frame_gate #(
        .C_s_axis_rxd_TDATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .VERDICT_TIMEOUT(TMO),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_rxd_tdata(i_rxd_tdata),
        .i_rxd_tvalid(i_rxd_tvalid),
        .i_rxd_tlast(i_rxd_tlast),
        .o_rxd_tready(o_rxd_tready),
        .i_verdict_valid(i_verdict_valid),
        .i_deny_data(i_deny_data),
        .o_txd_tdata(o_txd_tdata),
        .o_txd_tvalid(o_txd_tvalid),
        .o_txd_tlast(o_txd_tlast),
        .i_txd_tready(i_txd_tready),
        .o_frames_passed(o_frames_passed),
        .o_frames_dropped(o_frames_dropped),
        .o_verdict_timeouts(o_verdict_timeouts),
        .o_oversize(o_oversize)
    );

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_data[$];
    bit            exp_last[$];
    int            exp_passed = 0;
    int            exp_dropped = 0;
    int            exp_timeouts = 0;
    bit            exp_oversize = 1'b0;
    bit            sched_word[$];
    logic [DW-1:0] sched_data[$];
    bit            bp_mode = 1'b0;
    int            bp_idx = 0;
    bit            bp_pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    bit            hold_pending = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= (1 << CW) - 1) ? v : v + 1;
    endfunction

    // Word/gap schedule for one frame; returns its length in ingress cycles
    function automatic int build_frame(input int len, input logic [DW-1:0] base, input bit rnd, input int gap_pct);
        sched_word.delete();
        sched_data.delete();
        for (int w = 0; w < len; w++) begin
            if (w > 0 && int'($urandom_range(99)) < gap_pct) begin
                sched_word.push_back(1'b0);
                sched_data.push_back('0);
            end
            sched_word.push_back(1'b1);
            sched_data.push_back(rnd ? DW'($urandom) : base + DW'(w));
        end
        return sched_word.size();
    endfunction

    task automatic idle_inputs();
        i_rxd_tvalid    = 1'b0;
        i_rxd_tlast     = 1'b0;
        i_rxd_tdata     = '0;
        i_verdict_valid = 1'b0;
        i_deny_data     = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        idle_inputs();
        repeat (cycles - 1) @(posedge clk);
        @(negedge clk);
        check("reset_txd_tvalid", o_txd_tvalid, 1'b0);
        check("reset_txd_tlast", o_txd_tlast, 1'b0);
        check("reset_txd_tdata", o_txd_tdata, '0);
        check("reset_rxd_tready", o_rxd_tready, 1'b0);
        check("reset_passed", o_frames_passed, '0);
        check("reset_dropped", o_frames_dropped, '0);
        check("reset_timeouts", o_verdict_timeouts, '0);
        check("reset_oversize", o_oversize, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_data.delete();
        exp_last.delete();
        exp_passed   = 0;
        exp_dropped  = 0;
        exp_timeouts = 0;
        exp_oversize = 1'b0;
    endtask

    // Cycle k=0 is the first word. Verdict pulses at cycles v1/v2 (-1 = none); the earliest
    // pulse up to the last waiting cycle decides, otherwise the frame times out.
    task automatic run_frame(input int len, input int v1, input bit d1, input int v2, input bit d2);
        int d_cyc, dec, first_tx, done, wi, wait_n;
        bit has_v, pass, rx_ok;
        d_cyc  = sched_word.size();
        wait_n = 0;
        while (!o_rxd_tready && wait_n < 20) begin
            @(posedge clk);
            #1;
            wait_n++;
        end
        check("ingress_ready_idle", o_rxd_tready, 1'b1);

        has_v = (v1 >= 0) && (v1 <= d_cyc + TMO - 1);
        dec   = !has_v ? d_cyc + TMO - 1 : ((v1 > d_cyc) ? v1 : d_cyc);
        pass  = has_v && !d1 && (len <= DEPTH);
        if (pass) begin
            wi = 0;
            for (int k = 0; k < d_cyc; k++) begin
                if (sched_word[k]) begin
                    exp_data.push_back(sched_data[k]);
                    exp_last.push_back(wi == len - 1);
                    wi++;
                end
            end
            exp_passed = sat_inc(exp_passed);
        end else begin
            exp_dropped = sat_inc(exp_dropped);
            if (!has_v) exp_timeouts = sat_inc(exp_timeouts);
        end
        if (len > DEPTH) exp_oversize = 1'b1;

        first_tx = -1;
        done     = -1;
        rx_ok    = 1'b1;
        for (int k = 0; k < d_cyc + TMO + 600; k++) begin
            i_rxd_tvalid    = (k < d_cyc) && sched_word[k];
            i_rxd_tdata     = (k < d_cyc) ? sched_data[k] : '0;
            i_rxd_tlast     = (k == d_cyc - 1);
            i_verdict_valid = (k == v1) || (k == v2);
            i_deny_data     = (k == v1) ? d1 : ((k == v2) ? d2 : 1'b0);
            @(negedge clk);
            if (k < d_cyc && !o_rxd_tready) rx_ok = 1'b0;
            if (o_txd_tvalid && first_tx < 0) first_tx = k;
            if (k >= d_cyc && o_rxd_tready) done = k;
            @(posedge clk);
            #1;
            if (done >= 0) break;
        end
        idle_inputs();

        check("frame_done", done >= 0, 1'b1);
        check("ingress_ready_in_frame", rx_ok, 1'b1);
        if (pass) begin
            check("first_egress_cycle", first_tx, dec + 1);
        end else begin
            check("drop_done_cycle", done, dec + 2);
            check("no_egress_on_drop", first_tx, -1);
        end
        check("egress_drained", exp_data.size(), 0);
        check("frames_passed", o_frames_passed, exp_passed);
        check("frames_dropped", o_frames_dropped, exp_dropped);
        check("verdict_timeouts", o_verdict_timeouts, exp_timeouts);
        check("oversize_sticky", o_oversize, exp_oversize);
    endtask

    // Egress ready: random, or a fixed pattern stepped once per valid cycle
    initial begin
        i_txd_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                if (o_txd_tvalid) begin
                    i_txd_tready = (bp_idx < 7) ? bp_pat[bp_idx] : 1'b1;
                    bp_idx++;
                end else begin
                    i_txd_tready = 1'b0;
                end
            end else begin
                i_txd_tready = ($urandom_range(99) < 65);
            end
        end
    end

    // Egress monitor: every valid cycle must show the scoreboard head; pop on transfer
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pending = 1'b0;
            end else if (o_txd_tvalid) begin
                if (exp_data.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL egress_unexpected: got word 0x%0h, expected no egress", o_txd_tdata);
                end else begin
                    check("egress_data", o_txd_tdata, exp_data[0]);
                    check("egress_last", o_txd_tlast, exp_last[0]);
                    if (i_txd_tready) begin
                        void'(exp_data.pop_front());
                        void'(exp_last.pop_front());
                        hold_pending = 1'b0;
                    end else begin
                        hold_pending = 1'b1;
                    end
                end
            end else if (hold_pending) begin
                check("egress_hold_valid", o_txd_tvalid, 1'b1);
                hold_pending = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, v1, v2, len, sel;
        bit d1;
        do_reset(3);

        d = build_frame(16, 32'h0, 1'b0, 0);
        run_frame(16, 13, 1'b0, -1, 1'b0);

        d = build_frame(16, 32'h100, 1'b0, 0);
        run_frame(16, d + 1, 1'b1, -1, 1'b0);

        bp_mode = 1'b1;
        bp_idx  = 0;
        d = build_frame(4, 32'hA0, 1'b0, 0);
        run_frame(4, 0, 1'b0, -1, 1'b0);
        bp_mode = 1'b0;

        d = build_frame(8, 32'h200, 1'b0, 10);
        run_frame(8, -1, 1'b0, -1, 1'b0);

        d = build_frame(17, 32'h300, 1'b0, 0);
        run_frame(17, 2, 1'b0, -1, 1'b0);

        d = build_frame(20, 32'h400, 1'b0, 30);
        run_frame(20, d - 1, 1'b0, -1, 1'b0);

        d = build_frame(5, 32'h500, 1'b0, 0);
        run_frame(5, d + TMO - 1, 1'b0, -1, 1'b0);

        d = build_frame(5, 32'h600, 1'b0, 0);
        run_frame(5, d + TMO, 1'b0, -1, 1'b0);

        d = build_frame(1, 32'h700, 1'b0, 0);
        run_frame(1, 0, 1'b0, -1, 1'b0);

        d = build_frame(6, 32'h800, 1'b0, 0);
        run_frame(6, 2, 1'b1, 4, 1'b0);

        for (int f = 0; f < 50; f++) begin
            len = int'($urandom_range(1, 20));
            d   = build_frame(len, '0, 1'b1, 30);
            sel = int'($urandom_range(0, 9));
            if (sel < 2) v1 = -1;
            else if (sel == 2) v1 = d + TMO - 1 + int'($urandom_range(0, 1));
            else v1 = int'($urandom_range(0, d + 8));
            d1 = ($urandom_range(0, 3) == 0);
            v2 = (v1 >= 0 && $urandom_range(0, 1) == 1) ? v1 + 1 + int'($urandom_range(0, 4)) : -1;
            run_frame(len, v1, d1, v2, !d1);
        end

        while (!o_rxd_tready) begin
            @(posedge clk);
            #1;
        end
        for (int w = 0; w < 4; w++) begin
            i_rxd_tvalid = 1'b1;
            i_rxd_tdata  = DW'(w);
            i_rxd_tlast  = 1'b0;
            @(posedge clk);
            #1;
        end
        i_rxd_tdata = DW'(4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_reset(1);
        for (int f = 0; f < 3; f++) begin
            d = build_frame(10, 32'h900 + DW'(f * 16), 1'b0, 20);
            run_frame(10, 3, 1'b0, -1, 1'b0);
        end
        check("passed_after_reset", o_frames_passed, 3);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/acl_frame_gate.md
Name: acl_frame_gate

Overview:
Store-and-forward gate placed downstream of packet_parser. It buffers each received AXI-Stream frame, then forwards or discards it on the parser's allow/deny verdict. One frame is in flight at a time. Drop, pass and timeout counts are kept for status.

Parameters:
C_s_axis_rxd_TDATA_WIDTH, 32, stream word width in bits
FIFO_DEPTH, 512, frame buffer depth in words (max storable frame)
VERDICT_TIMEOUT, 64, cycles to wait for a verdict after tlast before forcing deny
CNT_WIDTH, 16, width of status counters

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
i_rxd_tdata  in  C_s_axis_rxd_TDATA_WIDTH  ingress word (same bus that feeds packet_parser)
i_rxd_tvalid  in  1  ingress word valid
i_rxd_tlast  in  1  ingress last word of frame
o_rxd_tready  out  1  ingress ready
i_verdict_valid  in  1  single-cycle pulse: parser verdict available
i_deny_data  in  1  verdict value, 1 = deny, sampled when i_verdict_valid=1
o_txd_tdata  out  C_s_axis_rxd_TDATA_WIDTH  egress word
o_txd_tvalid  out  1  egress valid
o_txd_tlast  out  1  egress last word
i_txd_tready  in  1  egress ready
o_frames_passed  out  CNT_WIDTH  frames forwarded
o_frames_dropped  out  CNT_WIDTH  frames discarded (deny, oversize or timeout)
o_verdict_timeouts  out  CNT_WIDTH  frames dropped due to verdict timeout
o_oversize  out  1  sticky: at least one frame exceeded FIFO_DEPTH; cleared only by rst

Behaviour:
- Reset (rst=1 at clock edge): state IDLE; write/read pointers, word count, verdict latch, oversize-in-frame flag and timer cleared.
- Reset values: all counters 0, o_oversize 0, o_txd_tvalid 0, o_txd_tlast 0, o_txd_tdata 0, o_rxd_tready 0.
- Reset mid-frame aborts the frame with no counter update.
- Handshake: a word transfers when tvalid && tready on the same edge. Egress data, valid and last stay stable while o_txd_tvalid=1 and i_txd_tready=0.
- o_rxd_tready is 1 in IDLE and RECV, 0 in WAIT, FORWARD and FLUSH. It is registered, deasserting the cycle after tlast is accepted.
- States:
  - IDLE: first accepted word is stored at address 0 and the state moves to RECV. If that word also has tlast, the state moves directly to WAIT.
  - RECV: each accepted word is stored at wr_ptr while wr_ptr < FIFO_DEPTH. Words beyond FIFO_DEPTH are accepted and discarded, and the oversize-in-frame flag and o_oversize are set. Accepting tlast moves the state to WAIT, with the word count = min(words received, FIFO_DEPTH).
  - WAIT: the timer increments each cycle.
    - If a verdict is latched, or i_verdict_valid=1 this cycle, the decision is made this cycle.
    - If the timer reaches VERDICT_TIMEOUT with no verdict, a deny is forced and o_verdict_timeouts increments.
    - Decision: allow and not oversize goes to FORWARD; otherwise FLUSH.
  - FORWARD: o_txd_tvalid=1 and o_txd_tdata=buf[rd_ptr]; o_txd_tlast=1 when rd_ptr = count-1. rd_ptr advances on each egress transfer. On the tlast transfer, o_frames_passed increments and the state returns to IDLE.
  - FLUSH: lasts one cycle; the buffer is never output. Pointers are cleared, o_frames_dropped increments, and the state returns to IDLE.
- Verdict latch: the first i_verdict_valid seen in IDLE (coincident with the first word), RECV or WAIT is latched. Later pulses for the same frame are ignored. Pulses while in FORWARD or FLUSH are ignored. A verdict coincident with tlast is latched.
- An oversize frame is always dropped, even with an allow verdict. It counts in o_frames_dropped only, not in o_verdict_timeouts unless it also timed out.
- Latency: the first egress word is valid the cycle after the WAIT decision cycle. Back-to-back frames need at least one IDLE cycle between them.
- Counters saturate at all-ones and do not wrap.
- Buffer: register or inferred RAM with combinational read at rd_ptr is acceptable, provided egress stability holds.

Test Plan:
- Allow path: 16-word frame with data 0x00000000..0x0000000F; verdict pulse (deny=0) on word 14. Expect the 16 identical words on egress, tlast on word 0x0F, o_frames_passed=1, o_frames_dropped=0.
- Deny path: 16-word frame; verdict deny=1 two cycles after tlast. Expect no o_txd_tvalid, FLUSH for one cycle, o_frames_dropped=1, then o_rxd_tready=1 in IDLE.
- Egress backpressure: allow a 4-word frame 0xA0..0xA3 while toggling i_txd_tready 1,0,0,1,0,1,1. Expect each word held stable until accepted, output order A0..A3, tlast only with A3.
- Timeout: 8-word frame, no verdict, VERDICT_TIMEOUT=64. Expect a drop 64 cycles after entering WAIT, o_verdict_timeouts=1, o_frames_dropped=1.
- Oversize: FIFO_DEPTH=9, 12-word frame, allow verdict. Expect all 12 words accepted (tready held), o_oversize=1, frame dropped, o_frames_passed=0.
- Reset mid-frame: rst=1 for 2 cycles during word 5 of a 10-word frame. Expect all outputs at reset values, counters 0, and the next 3 frames (repeated reset/allow loop) each passed, with o_frames_passed=3.
